raster_sequencer: RTL and testbench

RASTER_SEQUENCER -- requirements
Module: raster_sequencer

---
 rtl/raster_pkg.sv | 31 +++
 rtl/raster_cmd_fifo.sv | 58 +++++
 rtl/raster_sequencer.sv | 142 ++++++++++++++
 tb/tb_raster_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared definitions for the 8x8 raster sequencer: opcodes, FSM states, grid geometry.
// The optional command queue is selected by the RASTER_CMDQ_EN macro.
package raster_pkg;

  localparam int GRID   = 8;
  localparam int ADDR_W = 6;

  localparam logic [2:0] LAST_IDX = 3'(GRID - 1);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_SET   = 2'b01;
  localparam logic [1:0] CMD_HLINE = 2'b10;
  localparam logic [1:0] CMD_VLINE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  // Bit order matches the 8-bit queue entry {cmd, x, y}.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] x;
    logic [2:0] y;
  } cmd_t;

  function automatic logic [ADDR_W-1:0] start_addr(input cmd_t c);
    return (c.op == CMD_CLEAR) ? '0 : {c.y, c.x};
  endfunction

endpackage

// File: rtl/raster_cmd_fifo.sv
// Small register FIFO holding pending raster commands; combinational head output.
// Only instantiated when RASTER_CMDQ_EN is defined.
module raster_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign dout  = mem_reg[rd_ptr_reg];

  // A push into a full FIFO is legal only alongside a pop; the caller guarantees that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/raster_sequencer.sv
// Turns CLEAR/SET/HLINE/VLINE commands into one framebuffer write per cycle on an 8x8 grid.
// Define RASTER_CMDQ_EN to queue commands arriving while busy instead of dropping them.
module raster_sequencer
  import raster_pkg::*;
#(
  parameter logic CLEAR_VAL = 1'b0,
  parameter int   QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [2:0]        cmd_x,
  input  logic [2:0]        cmd_y,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_wdata,
  output logic              busy,
  output logic              done,
  output logic              cmd_drop
);

  state_t            state_reg;
  logic [1:0]        op_reg;
  cmd_t              in_cmd;
  cmd_t              start_cmd;
  logic              idle;
  logic              start;
  logic              drop_next;
  logic              last_write;
  logic [ADDR_W-1:0] addr_next;

  assign in_cmd = cmd_t'({cmd, cmd_x, cmd_y});
  assign idle   = (state_reg == ST_IDLE);

`ifdef RASTER_CMDQ_EN
  logic q_empty;
  logic q_full;
  logic q_push;
  logic q_pop;
  logic push_req;
  cmd_t q_head;

  // Anything arriving while busy, or behind already-queued work, goes through the queue.
  always_comb begin
    push_req  = cmd_valid && (busy || !q_empty);
    q_pop     = idle && !q_empty;
    q_push    = push_req && (!q_full || q_pop);
    drop_next = push_req && q_full && !q_pop;
    start     = idle && (!q_empty || cmd_valid);
    start_cmd = q_empty ? in_cmd : q_head;
  end

  raster_cmd_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (8)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (in_cmd),
    .pop   (q_pop),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );
`else
  always_comb begin
    start     = idle && cmd_valid;
    start_cmd = in_cmd;
    drop_next = cmd_valid && busy;
  end

  // QDEPTH only sizes the command queue, which this build does not have.
  if (QDEPTH < 1) begin : g_qdepth_unused
  end
`endif

  // fb_addr doubles as the draw position: row in [5:3], column in [2:0].
  always_comb begin
    last_write = 1'b1;
    addr_next  = fb_addr;
    case (op_reg)
      CMD_CLEAR: begin
        last_write = &fb_addr;
        addr_next  = fb_addr + ADDR_W'(1);
      end
      CMD_HLINE: begin
        last_write = (fb_addr[2:0] == LAST_IDX);
        addr_next  = {fb_addr[5:3], fb_addr[2:0] + 3'd1};
      end
      CMD_VLINE: begin
        last_write = (fb_addr[5:3] == LAST_IDX);
        addr_next  = {fb_addr[5:3] + 3'd1, fb_addr[2:0]};
      end
      default: begin
        last_write = 1'b1;
        addr_next  = fb_addr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= CMD_CLEAR;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      done     <= 1'b0;
      cmd_drop <= drop_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_DRAW;
            op_reg    <= start_cmd.op;
            fb_we     <= 1'b1;
            busy      <= 1'b1;
            fb_addr   <= start_addr(start_cmd);
            fb_wdata  <= (start_cmd.op == CMD_CLEAR) ? CLEAR_VAL : 1'b1;
          end
        end
        ST_DRAW: begin
          if (last_write) begin
            state_reg <= ST_IDLE;
            fb_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            fb_addr <= addr_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer: table vectors, queue/drop and reset corner cases,
// and random commands checked against a write-list model. Adapts to RASTER_CMDQ_EN.
module tb_raster_sequencer;
  import raster_pkg::*;

  localparam logic CLEAR_VAL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [2:0] cmd_x = 3'd0;
  logic [2:0] cmd_y = 3'd0;
  logic       fb_we;
  logic [5:0] fb_addr;
  logic       fb_wdata;
  logic       busy;
  logic       done;
  logic       cmd_drop;

  raster_sequencer #(
    .CLEAR_VAL (CLEAR_VAL),
    .QDEPTH    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .busy      (busy),
    .done      (done),
    .cmd_drop  (cmd_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle on the falling edge.
  int w_cyc[$];
  int w_addr[$];
  int w_data[$];
  int d_cyc[$];
  int drop_cyc[$];
  int busy_cnt = 0;
  int bad_cnt  = 0;
  int widx     = 0;
  int didx     = 0;

  always @(negedge clk) begin
    if (fb_we) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(int'(fb_addr));
      w_data.push_back(int'(fb_wdata));
    end
    if (done) d_cyc.push_back(cyc);
    if (cmd_drop) drop_cyc.push_back(cyc);
    if (busy) busy_cnt++;
    if ((fb_we && !busy) || (done && busy)) bad_cnt++;
  end

  task automatic clear_log();
    w_cyc.delete();
    w_addr.delete();
    w_data.delete();
    d_cyc.delete();
    drop_cyc.delete();
    busy_cnt = 0;
    widx     = 0;
    didx     = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the full list of (address, data) writes a command must produce.
  int exp_a[$];
  int exp_d[$];

  task automatic build_expected(input logic [1:0] op, input int x, input int y);
    exp_a.delete();
    exp_d.delete();
    case (op)
      CMD_CLEAR: for (int a = 0; a < GRID * GRID; a++) begin
        exp_a.push_back(a);
        exp_d.push_back(int'(CLEAR_VAL));
      end
      CMD_SET: begin
        exp_a.push_back(y * GRID + x);
        exp_d.push_back(1);
      end
      CMD_HLINE: for (int c = x; c < GRID; c++) begin
        exp_a.push_back(y * GRID + c);
        exp_d.push_back(1);
      end
      default: for (int r = y; r < GRID; r++) begin
        exp_a.push_back(r * GRID + x);
        exp_d.push_back(1);
      end
    endcase
  endtask

  // Command captured at the edge that made cyc == c0: write k at cycle c0+k, done at c0+n.
  task automatic check_cmd(input string tag, input logic [1:0] op, input logic [2:0] x,
                           input logic [2:0] y, input int c0);
    int n;
    build_expected(op, int'(x), int'(y));
    n = exp_a.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s write[%0d] present", tag, k), (widx < w_addr.size()) ? 1 : 0, 1);
      if (widx < w_addr.size()) begin
        chk($sformatf("%s addr[%0d]", tag, k), w_addr[widx], exp_a[k]);
        chk($sformatf("%s wdata[%0d]", tag, k), w_data[widx], exp_d[k]);
        chk($sformatf("%s cycle[%0d]", tag, k), w_cyc[widx], c0 + k);
      end
      widx++;
    end
    chk({tag, " done present"}, (didx < d_cyc.size()) ? 1 : 0, 1);
    if (didx < d_cyc.size()) chk({tag, " done cycle"}, d_cyc[didx], c0 + n);
    didx++;
  endtask

  // Called at #1 after a rising edge; returns the cycle number of the capturing edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] x, input logic [2:0] y,
                       output int c);
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_x     = x;
    cmd_y     = y;
    @(posedge clk);
    #1;
    c         = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] x;
    logic [2:0] y;
    int         exp_n;
    int         exp_first;
    int         exp_last;
    logic       exp_wd;
  } vec_t;

  vec_t tv[10];

  initial begin
    int c0;
    int c1;
    int n;
    logic [1:0] r_op[25];
    logic [2:0] r_x[25];
    logic [2:0] r_y[25];
    int         r_c[25];

    tv[0] = '{CMD_SET,   3'd3, 3'd5,  1, 43, 43, 1'b1};
    tv[1] = '{CMD_CLEAR, 3'd0, 3'd0, 64,  0, 63, CLEAR_VAL};
    tv[2] = '{CMD_HLINE, 3'd7, 3'd2,  1, 23, 23, 1'b1};
    tv[3] = '{CMD_VLINE, 3'd1, 3'd4,  4, 33, 57, 1'b1};
    tv[4] = '{CMD_HLINE, 3'd0, 3'd6,  8, 48, 55, 1'b1};
    tv[5] = '{CMD_VLINE, 3'd7, 3'd0,  8,  7, 63, 1'b1};
    tv[6] = '{CMD_SET,   3'd0, 3'd7,  1, 56, 56, 1'b1};
    tv[7] = '{CMD_VLINE, 3'd5, 3'd7,  1, 61, 61, 1'b1};
    tv[8] = '{CMD_HLINE, 3'd4, 3'd3,  4, 28, 31, 1'b1};
    tv[9] = '{CMD_CLEAR, 3'd5, 3'd3, 64,  0, 63, CLEAR_VAL};

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset fb_we", fb_we, 0);
    chk("reset fb_addr", fb_addr, 0);
    chk("reset fb_wdata", fb_wdata, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset cmd_drop", cmd_drop, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    foreach (tv[i]) begin
      clear_log();
      issue(tv[i].op, tv[i].x, tv[i].y, c0);
      step(tv[i].exp_n + 3);
      $display("vec%0d op=%0d x=%0d y=%0d writes=%0d", i, tv[i].op, tv[i].x, tv[i].y, w_addr.size());
      chk($sformatf("vec%0d write count", i), w_addr.size(), tv[i].exp_n);
      if (w_addr.size() > 0) begin
        chk($sformatf("vec%0d first addr", i), w_addr[0], tv[i].exp_first);
        chk($sformatf("vec%0d last addr", i), w_addr[w_addr.size() - 1], tv[i].exp_last);
        chk($sformatf("vec%0d wdata", i), w_data[0], tv[i].exp_wd);
      end
      chk($sformatf("vec%0d busy cycles", i), busy_cnt, tv[i].exp_n);
      chk($sformatf("vec%0d drops", i), drop_cyc.size(), 0);
      check_cmd($sformatf("vec%0d", i), tv[i].op, tv[i].x, tv[i].y, c0);
    end

    // CLEAR, then SET on the very next cycle.
    clear_log();
    issue(CMD_CLEAR, 3'd0, 3'd0, c0);
    issue(CMD_SET, 3'd2, 3'd3, c1);
    step(72);
    check_cmd("clr+set CLEAR", CMD_CLEAR, 3'd0, 3'd0, c0);
`ifdef RASTER_CMDQ_EN
    check_cmd("clr+set SET", CMD_SET, 3'd2, 3'd3, c0 + 65);
    chk("clr+set drops", drop_cyc.size(), 0);
`else
    chk("clr+set drops", drop_cyc.size(), 1);
`endif
    chk("clr+set stray writes", w_addr.size(), widx);
    chk("clr+set done count", d_cyc.size(), didx);
    $display("clr+set writes=%0d drops=%0d", w_addr.size(), drop_cyc.size());

`ifdef RASTER_CMDQ_EN
    // Three SETs during a CLEAR with a two-entry queue: the third is dropped.
    clear_log();
    issue(CMD_CLEAR, 3'd0, 3'd0, c0);
    step(3);
    issue(CMD_SET, 3'd1, 3'd1, c1);
    step(3);
    issue(CMD_SET, 3'd2, 3'd2, c1);
    step(3);
    issue(CMD_SET, 3'd3, 3'd3, c1);
    step(75);
    check_cmd("3set CLEAR", CMD_CLEAR, 3'd0, 3'd0, c0);
    check_cmd("3set SET1", CMD_SET, 3'd1, 3'd1, c0 + 65);
    check_cmd("3set SET2", CMD_SET, 3'd2, 3'd2, c0 + 67);
    chk("3set drops", drop_cyc.size(), 1);
    chk("3set stray writes", w_addr.size(), widx);
    chk("3set done count", d_cyc.size(), 3);
    $display("3set writes=%0d drops=%0d", w_addr.size(), drop_cyc.size());
`endif

    // Reset in the middle of a CLEAR, with a SET pending behind it.
    clear_log();
    issue(CMD_CLEAR, 3'd0, 3'd0, c0);
    issue(CMD_SET, 3'd5, 3'd5, c1);
    step(19);
    chk("pre-reset addr", fb_addr, 20);
    rst_n = 1'b0;
    #1;
    chk("midreset fb_we", fb_we, 0);
    chk("midreset fb_addr", fb_addr, 0);
    chk("midreset fb_wdata", fb_wdata, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset cmd_drop", cmd_drop, 0);
    chk("midreset writes before reset", w_addr.size(), 20);
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_log();
    issue(CMD_SET, 3'd0, 3'd0, c0);
    step(8);
    check_cmd("post-reset SET", CMD_SET, 3'd0, 3'd0, c0);
    chk("post-reset stray writes", w_addr.size(), widx);
    chk("post-reset done count", d_cyc.size(), 1);
    chk("post-reset drops", drop_cyc.size(), 0);
    $display("reset test writes=%0d", w_addr.size());

    // Random commands, each issued in its predecessor's done cycle or a little later.
    clear_log();
    for (int i = 0; i < 25; i++) begin
      r_op[i] = 2'($urandom_range(0, 3));
      if (r_op[i] == CMD_CLEAR && $urandom_range(0, 2) != 0) r_op[i] = CMD_SET;
      r_x[i] = 3'($urandom_range(0, 7));
      r_y[i] = 3'($urandom_range(0, 7));
      issue(r_op[i], r_x[i], r_y[i], r_c[i]);
      build_expected(r_op[i], int'(r_x[i]), int'(r_y[i]));
      n = exp_a.size();
      step(n + $urandom_range(0, 2));
    end
    step(4);
    for (int i = 0; i < 25; i++) begin
      check_cmd($sformatf("rand%0d", i), r_op[i], r_x[i], r_y[i], r_c[i]);
      $display("rand%0d op=%0d x=%0d y=%0d", i, r_op[i], r_x[i], r_y[i]);
    end
    chk("rand stray writes", w_addr.size(), widx);
    chk("rand done count", d_cyc.size(), 25);
    chk("rand drops", drop_cyc.size(), 0);

    chk("fb_we or done outside expected busy state", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
